// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - paddle position controller with move-tick divider and speed ramp
module paddle_ctrl #(
   parameter int         SCREEN_W   = 160,
   parameter int         POS_W      = 8,
   parameter int         LEN_W      = 5,
   parameter int         TICK_DIV   = 833333,
   parameter int         TICK_CNT_W = 20,
   parameter int         MAX_SPEED  = 4,
   parameter int         RAMP_TICKS = 8,
   parameter logic [2:0] ST_PLAY    = 3'b001,
   parameter logic [2:0] ST_SERVE   = 3'b010
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       state,
   input  logic             move_en,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic [LEN_W-1:0] length,
   output logic [POS_W-1:0] paddle_x,
   output logic [2:0]       speed,
   output logic             at_left,
   output logic             at_right,
   output logic             tick_out
);

   // One extra bit over the wider operand so x+length and x+step never wrap.
   localparam int SUM_W  = ((POS_W > LEN_W) ? POS_W : LEN_W) + 1;
   localparam int HOLD_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam logic [SUM_W-1:0] SCREEN_V = SUM_W'(SCREEN_W);

   typedef enum logic [1:0] {S_IDLE, S_HOLD_L, S_HOLD_R} fsm_t;

   fsm_t                  r_fsm, w_fsm_nxt;
   logic [2:0]            r_speed, w_speed_nxt;
   logic [HOLD_W-1:0]     r_hold, w_hold_nxt;
   logic [POS_W-1:0]      r_x, w_x_nxt;
   logic [2:0]            r_prev_state;
   logic [TICK_CNT_W-1:0] r_tick_cnt;

   logic             w_tick, w_active, w_dir_l, w_dir_r, w_same, w_recentre;
   logic [SUM_W-1:0] w_x_ext, w_sum, w_limit, w_step, w_right_sum;

   assign w_tick     = (r_tick_cnt == TICK_CNT_W'(TICK_DIV - 1));
   assign w_active   = ((state == ST_PLAY) || (state == ST_SERVE)) && move_en;
   assign w_dir_r    = btn_right && !btn_left;
   assign w_dir_l    = btn_left && !btn_right;
   assign w_same     = (w_dir_r && (r_fsm == S_HOLD_R)) || (w_dir_l && (r_fsm == S_HOLD_L));
   assign w_recentre = (state == ST_SERVE) && (r_prev_state != ST_SERVE);

   assign w_x_ext     = SUM_W'(r_x);
   assign w_sum       = w_x_ext + SUM_W'(length);
   assign w_limit     = (SUM_W'(length) >= SCREEN_V) ? '0 : SCREEN_V - SUM_W'(length);
   assign w_step      = SUM_W'(w_speed_nxt);
   assign w_right_sum = w_x_ext + w_step;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_fsm        <= S_IDLE;
         r_speed      <= '0;
         r_hold       <= '0;
         r_x          <= '0;
         r_prev_state <= 3'b000;
         r_tick_cnt   <= '0;
      end else begin
         r_fsm        <= w_fsm_nxt;
         r_speed      <= w_speed_nxt;
         r_hold       <= w_hold_nxt;
         r_x          <= w_x_nxt;
         r_prev_state <= state;
         r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
      end
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      if (!w_active || w_recentre)
         w_fsm_nxt = S_IDLE;
      else if (w_tick) begin
         if (w_dir_r)
            w_fsm_nxt = S_HOLD_R;
         else if (w_dir_l)
            w_fsm_nxt = S_HOLD_L;
         else
            w_fsm_nxt = S_IDLE;
      end
   end

   always_comb begin
      w_speed_nxt = r_speed;
      w_hold_nxt  = r_hold;
      if (!w_active || w_recentre) begin
         w_speed_nxt = '0;
         w_hold_nxt  = '0;
      end else if (w_tick) begin
         if (!w_dir_l && !w_dir_r) begin
            w_speed_nxt = '0;
            w_hold_nxt  = '0;
         end else if (!w_same) begin
            w_speed_nxt = 3'd1;
            w_hold_nxt  = '0;
         end else if (r_hold == HOLD_W'(RAMP_TICKS - 1)) begin
            w_hold_nxt = '0;
            if (r_speed < 3'(MAX_SPEED))
               w_speed_nxt = r_speed + 3'd1;
         end else begin
            w_hold_nxt = r_hold + 1'b1;
         end
      end
   end

   // Step uses the speed being written this tick, so the first press moves 1 pixel.
   always_comb begin
      w_x_nxt = r_x;
      if (w_recentre)
         w_x_nxt = POS_W'(w_limit >> 1);
      else if (w_sum > SCREEN_V)
         w_x_nxt = POS_W'(w_limit);
      else if (w_active && w_tick && w_dir_r)
         w_x_nxt = (w_right_sum > w_limit) ? POS_W'(w_limit) : POS_W'(w_right_sum);
      else if (w_active && w_tick && w_dir_l)
         w_x_nxt = (w_x_ext >= w_step) ? POS_W'(w_x_ext - w_step) : '0;
   end

   assign paddle_x = r_x;
   assign speed    = r_speed;
   assign at_left  = (r_x == '0);
   assign at_right = (w_sum >= SCREEN_V);
   assign tick_out = w_tick;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - randomized scoreboard bench for paddle_ctrl
module tb_paddle_ctrl;

   localparam int SCR  = 160;
   localparam int TDIV = 4;
   localparam int RAMP = 2;
   localparam int MAXS = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] state = 3'b000;
   logic       move_en = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic [4:0] length = 5'd20;
   logic [7:0] paddle_x;
   logic [2:0] speed;
   logic       at_left, at_right, tick_out;

   paddle_ctrl #(
      .SCREEN_W(SCR), .POS_W(8), .LEN_W(5), .TICK_DIV(TDIV), .TICK_CNT_W(2),
      .MAX_SPEED(MAXS), .RAMP_TICKS(RAMP), .ST_PLAY(3'b001), .ST_SERVE(3'b010)
   ) dut (
      .clock(clock), .reset(reset), .state(state), .move_en(move_en),
      .btn_left(btn_left), .btn_right(btn_right), .length(length),
      .paddle_x(paddle_x), .speed(speed), .at_left(at_left),
      .at_right(at_right), .tick_out(tick_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      int x;
      int spd;
      int al;
      int ar;
      int tk;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: direction as -1/0/+1, plain integer arithmetic
   int m_x = 0, m_spd = 0, m_hold = 0, m_dir = 0, m_cnt = 0, m_prev = 0;

   task automatic chk(input string name, input logic [15:0] act, input int exp);
      n_checks++;
      if (act !== 16'(exp)) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic drive(input bit rst, input int st, input bit en,
                        input bit bl, input bit br, input int len);
      bit tk, act, rc;
      int d, lim;
      exp_t e;
      @(negedge clock);
      reset = rst; state = 3'(st); move_en = en;
      btn_left = bl; btn_right = br; length = 5'(len);
      if (!rst) begin
         m_x = 0; m_spd = 0; m_hold = 0; m_dir = 0; m_cnt = 0; m_prev = 0;
      end else begin
         tk    = (m_cnt == TDIV - 1);
         m_cnt = tk ? 0 : m_cnt + 1;
         act   = (st == 1 || st == 2) && en;
         d     = (br && !bl) ? 1 : (bl && !br) ? -1 : 0;
         rc    = (st == 2) && (m_prev != 2);
         lim   = (len >= SCR) ? 0 : SCR - len;
         if (!act || rc) begin
            m_dir = 0; m_spd = 0; m_hold = 0;
         end else if (tk) begin
            if (d == 0) begin
               m_dir = 0; m_spd = 0; m_hold = 0;
            end else if (d != m_dir) begin
               m_dir = d; m_spd = 1; m_hold = 0;
            end else if (m_hold == RAMP - 1) begin
               m_hold = 0;
               if (m_spd < MAXS) m_spd++;
            end else begin
               m_hold++;
            end
         end
         if (rc)
            m_x = lim / 2;
         else if (m_x + len > SCR)
            m_x = lim;
         else if (act && tk && d > 0)
            m_x = (m_x + m_spd > lim) ? lim : m_x + m_spd;
         else if (act && tk && d < 0)
            m_x = (m_x >= m_spd) ? m_x - m_spd : 0;
         m_prev = st;
      end
      e.x  = m_x;
      e.spd = m_spd;
      e.al = (m_x == 0);
      e.ar = (m_x + len >= SCR);
      e.tk = (m_cnt == TDIV - 1);
      q.push_back(e);
   endtask

   always @(posedge clock) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("paddle_x", 16'(paddle_x), e.x);
         chk("speed",    16'(speed),    e.spd);
         chk("at_left",  16'(at_left),  e.al);
         chk("at_right", 16'(at_right), e.ar);
         chk("tick_out", 16'(tick_out), e.tk);
      end
   end

   initial begin
      int st, len, seg_len, r;
      bit en, bl, br, rst;
      len = 20;
      repeat (3) drive(0, 0, 0, 0, 0, len);
      // Long rightward run from reset reaches the right edge and saturates.
      repeat (260) drive(1, 1, 1, 0, 1, len);
      repeat (30) drive(1, 1, 1, 1, 1, len);
      repeat (40) drive(1, 1, 1, 1, 0, len);
      drive(1, 1, 1, 0, 1, 31);
      repeat (20) drive(1, 2, 1, 0, 1, 20);
      repeat (400) drive(1, 1, 1, 1, 0, 20);
      for (int s = 0; s < 60; s++) begin
         r  = $urandom_range(99);
         st = (r < 65) ? 1 : (r < 82) ? 2 : (r < 94) ? 0 : $urandom_range(3, 7);
         en = ($urandom_range(9) != 0);
         r  = $urandom_range(9);
         bl = (r < 4) || (r == 8);
         br = (r >= 4 && r < 8) || (r == 8);
         if ($urandom_range(4) == 0) len = $urandom_range(8, 31);
         seg_len = $urandom_range(20, 150);
         for (int c = 0; c < seg_len; c++) begin
            if ($urandom_range(49) == 0) len = $urandom_range(8, 31);
            rst = ($urandom_range(199) != 0);
            drive(rst, st, en, bl, br, len);
         end
      end
      repeat (6) @(posedge clock);
      #2;
      chk("queue_drained", 16'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
